multicycle_control: RTL and testbench

Multi-cycle sequencer for the single-issue RISC-V datapath. Steps each instruction through fetch, decode, execute and writeback. Generates the per-cycle ALU, register-file, IR and PC enables. Runs a start/done handshake with the iterative multiplier (funct7 = 0000001), keeps a retired-instruction count, and traps on unsupported opcodes or a hung multiplier.

---
 rtl/multicycle_control.sv | 155 +++++++++++++++
 tb/tb_multicycle_control.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer with an iterative-multiplier handshake,
// retired-instruction counter and a sticky trap for illegal opcodes or a hung multiplier.
module multicycle_control #(
  parameter int MUL_TIMEOUT = 32,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [6:0]       Op_i,
  input  logic [6:0]       funct7_i,
  input  logic             imem_ready_i,
  input  logic             mul_done_i,
  output logic             imem_req_o,
  output logic             IRWrite_o,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             mul_start_o,
  output logic             RegWrite_o,
  output logic             PCWrite_o,
  output logic             illegal_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  // state   | meaning
  // IDLE    | waiting for start_i
  // FETCH   | imem request outstanding, IR loads when imem_ready_i
  // DECODE  | latch ALUOp/ALUSrc, dispatch on opcode/funct7
  // EXEC    | ALU settles, no enables
  // MULWAIT | waiting for mul_done_i, bounded by MUL_TIMEOUT
  // WB      | register write, PC advance, retire
  // TRAP    | terminal until reset, illegal_o held
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MULWAIT = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd6
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] F7_MUL = 7'b0000001;
  localparam logic [7:0] MUL_TO = 8'(MUL_TIMEOUT);

  state_e           state_q;
  logic             imem_req_q;
  logic [1:0]       alu_op_q;
  logic             alu_src_q;
  logic             mul_start_q;
  logic             reg_write_q;
  logic             pc_write_q;
  logic             illegal_q;
  logic [7:0]       mul_cnt_q;
  logic [CNT_W-1:0] retired_q;

  // Enables are registered one edge ahead of the state they belong to, so every
  // output except IRWrite_o is a clean Moore output.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      imem_req_q  <= 1'b0;
      alu_op_q    <= 2'b00;
      alu_src_q   <= 1'b0;
      mul_start_q <= 1'b0;
      reg_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
      illegal_q   <= 1'b0;
      mul_cnt_q   <= 8'd0;
      retired_q   <= '0;
    end else begin
      imem_req_q  <= 1'b0;
      mul_start_q <= 1'b0;
      reg_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ready_i) state_q <= S_DECODE;
          else              imem_req_q <= 1'b1;
        end
        S_DECODE: begin
          if (Op_i == OP_R) begin
            alu_src_q <= 1'b0;
            if (funct7_i == F7_MUL) begin
              alu_op_q    <= 2'b11;
              mul_start_q <= 1'b1;
              mul_cnt_q   <= 8'd0;
              state_q     <= S_MULWAIT;
            end else begin
              alu_op_q <= 2'b10;
              state_q  <= S_EXEC;
            end
          end else if (Op_i == OP_I) begin
            alu_op_q  <= 2'b00;
            alu_src_q <= 1'b1;
            state_q   <= S_EXEC;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= S_TRAP;
          end
        end
        S_EXEC: begin
          state_q     <= S_WB;
          reg_write_q <= 1'b1;
          pc_write_q  <= 1'b1;
        end
        S_MULWAIT: begin
          // done wins over a timeout landing in the same cycle
          if (mul_done_i) begin
            state_q     <= S_WB;
            reg_write_q <= 1'b1;
            pc_write_q  <= 1'b1;
          end else if (mul_cnt_q + 8'd1 == MUL_TO) begin
            illegal_q <= 1'b1;
            state_q   <= S_TRAP;
          end else begin
            mul_cnt_q <= mul_cnt_q + 8'd1;
          end
        end
        S_WB: begin
          retired_q <= retired_q + CNT_W'(1);
          if (start_i) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_TRAP: state_q <= S_TRAP;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign IRWrite_o   = (state_q == S_FETCH) && imem_ready_i;
  assign imem_req_o  = imem_req_q;
  assign ALUOp_o     = alu_op_q;
  assign ALUSrc_o    = alu_src_q;
  assign mul_start_o = mul_start_q;
  assign RegWrite_o  = reg_write_q;
  assign PCWrite_o   = pc_write_q;
  assign illegal_o   = illegal_q;
  assign state_o     = state_q;
  assign retired_o   = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: dut_a uses default parameters, dut_b uses
// MUL_TIMEOUT=4 / CNT_W=4 for the hang and wrap cases; one monitor watches the selected DUT.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       start, imem_ready, mul_done;
  logic [6:0] op, f7;
  logic       sel;

  logic        a_req, a_irw, a_src, a_ms, a_rw, a_pw, a_ill;
  logic [1:0]  a_aluop;
  logic [2:0]  a_state;
  logic [31:0] a_ret;
  logic        b_req, b_irw, b_src, b_ms, b_rw, b_pw, b_ill;
  logic [1:0]  b_aluop;
  logic [2:0]  b_state;
  logic [3:0]  b_ret;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  always #5 clk = ~clk;

  multicycle_control #(.MUL_TIMEOUT(32), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .start_i(start), .Op_i(op), .funct7_i(f7),
    .imem_ready_i(imem_ready), .mul_done_i(mul_done), .imem_req_o(a_req),
    .IRWrite_o(a_irw), .ALUOp_o(a_aluop), .ALUSrc_o(a_src), .mul_start_o(a_ms),
    .RegWrite_o(a_rw), .PCWrite_o(a_pw), .illegal_o(a_ill), .state_o(a_state),
    .retired_o(a_ret));

  multicycle_control #(.MUL_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start), .Op_i(op), .funct7_i(f7),
    .imem_ready_i(imem_ready), .mul_done_i(mul_done), .imem_req_o(b_req),
    .IRWrite_o(b_irw), .ALUOp_o(b_aluop), .ALUSrc_o(b_src), .mul_start_o(b_ms),
    .RegWrite_o(b_rw), .PCWrite_o(b_pw), .illegal_o(b_ill), .state_o(b_state),
    .retired_o(b_ret));

  wire        m_rst   = sel ? rst_b : rst_a;
  wire        m_req   = sel ? b_req : a_req;
  wire        m_irw   = sel ? b_irw : a_irw;
  wire        m_src   = sel ? b_src : a_src;
  wire        m_ms    = sel ? b_ms : a_ms;
  wire        m_rw    = sel ? b_rw : a_rw;
  wire        m_pw    = sel ? b_pw : a_pw;
  wire        m_ill   = sel ? b_ill : a_ill;
  wire [1:0]  m_aluop = sel ? b_aluop : a_aluop;
  wire [2:0]  m_state = sel ? b_state : a_state;
  wire [31:0] m_ret   = sel ? {28'd0, b_ret} : a_ret;
  wire [31:0] m_mask  = sel ? 32'h0000_000F : 32'hFFFF_FFFF;

  typedef struct {
    bit          trap;
    logic [1:0]  aluop;
    logic        alusrc;
    int          cyc;
    int          fcyc;
    int          irw;
    int          ms;
    logic [31:0] ret;
    logic [2:0]  nxt;
  } item_t;

  item_t sbq[$];
  int    total = 0;
  int    bad = 0;
  logic [31:0] exp_ret;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (m_state !== s && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_state", m_state, s);
  endtask

  task automatic push(input bit trap, input logic [1:0] aluop, input logic alusrc,
                      input int cyc, input int fcyc, input int irw, input int ms,
                      input logic [31:0] ret, input logic [2:0] nxt);
    item_t it;
    it.trap = trap; it.aluop = aluop; it.alusrc = alusrc; it.cyc = cyc;
    it.fcyc = fcyc; it.irw = irw; it.ms = ms; it.ret = ret; it.nxt = nxt;
    sbq.push_back(it);
  endtask

  // back-to-back instructions with start held; even slots R-type, odd slots I-type
  task automatic b2b(input int n, input bit all_r);
    for (int k = 0; k < n; k++) begin
      bit is_i;
      is_i = !all_r && (k % 2 == 1);
      exp_ret++;
      push(0, is_i ? 2'b00 : 2'b10, is_i, 4, 1, 1, 0, exp_ret, (k < n - 1) ? 3'd1 : 3'd0);
    end
    start = 1; imem_ready = 1; f7 = 7'd0;
    for (int k = 0; k < n; k++) begin
      op = (!all_r && (k % 2 == 1)) ? OP_I : OP_R;
      wait_state(3'd2, 12);
      if (k == n - 1) start = 0;
      wait_state(3'd5, 8);
    end
    wait_state(3'd0, 4);
  endtask

  // monitor
  int    cyc, fcyc, irw_n, ms_n, stray, reqmiss;
  bit    in_instr = 0, pend = 0;
  item_t pend_item;
  logic [2:0] prev_st = 3'd0;

  always @(negedge clk) begin
    if (!m_rst) begin
      in_instr = 0; pend = 0; prev_st = 3'd0;
    end else begin
      if (pend) begin
        chk("retired", m_ret & m_mask, pend_item.ret & m_mask);
        chk("after_wb_state", m_state, pend_item.nxt);
        pend = 0;
      end
      if (m_state == 3'd1 && prev_st != 3'd1) begin
        in_instr = 1; cyc = 0; fcyc = 0; irw_n = 0; ms_n = 0; stray = 0; reqmiss = 0;
      end
      if (in_instr && m_state >= 3'd1 && m_state <= 3'd5) begin
        cyc++;
        if (m_state == 3'd1) begin
          fcyc++;
          if (!m_req) reqmiss++;
        end
        irw_n += int'(m_irw);
        ms_n  += int'(m_ms);
        if (m_state != 3'd5 && (m_rw || m_pw)) stray++;
        if (m_state >= 3'd3 && sbq.size() > 0) begin
          chk("aluop_hold", m_aluop, sbq[0].aluop);
          chk("alusrc_hold", m_src, sbq[0].alusrc);
        end
      end
      if (m_state == 3'd5 && in_instr) begin
        in_instr = 0;
        if (sbq.size() == 0) chk("sb_unexpected_retire", 1, 0);
        else begin
          pend_item = sbq.pop_front();
          pend = 1;
          chk("kind_retire", 0, pend_item.trap);
          chk("instr_cycles", cyc, pend_item.cyc);
          chk("fetch_cycles", fcyc, pend_item.fcyc);
          chk("irwrite_pulses", irw_n, pend_item.irw);
          chk("mulstart_pulses", ms_n, pend_item.ms);
          chk("wb_enables", {m_rw, m_pw}, 2'b11);
          chk("stray_enables", stray, 0);
          chk("imem_req_fetch", reqmiss, 0);
        end
      end
      if (m_state == 3'd6) begin
        if (prev_st != 3'd6) begin
          in_instr = 0;
          if (sbq.size() == 0) chk("sb_unexpected_trap", 1, 0);
          else begin
            item_t it;
            it = sbq.pop_front();
            chk("kind_trap", 1, it.trap);
            chk("trap_cycles", cyc, it.cyc);
            chk("trap_mulstart", ms_n, it.ms);
            chk("trap_aluop_kept", m_aluop, it.aluop);
            chk("trap_stray", stray, 0);
          end
        end
        chk("trap_outputs", {m_ill, m_req, m_irw, m_ms, m_rw, m_pw}, 6'b100000);
      end
      prev_st = m_state;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; rst_a = 0; rst_b = 0;
    start = 0; imem_ready = 0; mul_done = 0; op = 7'd0; f7 = 7'd0;
    exp_ret = 0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); imem_ready = 1'($urandom); mul_done = 1'($urandom);
      op = 7'($urandom); f7 = 7'($urandom);
      @(negedge clk);
      chk("reset_outputs", {a_req, a_irw, a_aluop, a_src, a_ms, a_rw, a_pw, a_ill, a_state, a_ret}, 44'd0);
    end
    @(posedge clk); #1;
    start = 0; imem_ready = 0; mul_done = 0; op = 7'd0; f7 = 7'd0;
    rst_a = 1;
    step(3);
    @(negedge clk);
    chk("idle_after_release", a_state, 3'd0);
    step(1);

    // R-type ADD
    exp_ret++;
    push(0, 2'b10, 0, 4, 1, 1, 0, exp_ret, 3'd0);
    op = OP_R; f7 = 7'd0; imem_ready = 1; start = 1;
    wait_state(3'd2, 10);
    start = 0;
    wait_state(3'd0, 10);

    // ADDI with three wait cycles; mul_done during FETCH must be ignored
    exp_ret++;
    push(0, 2'b00, 1, 7, 4, 1, 0, exp_ret, 3'd0);
    op = OP_I; imem_ready = 0; mul_done = 1; start = 1;
    wait_state(3'd1, 10);
    step(3);
    imem_ready = 1; start = 0; mul_done = 0;
    wait_state(3'd0, 20);

    // MUL, done on the 5th MULWAIT cycle
    exp_ret++;
    push(0, 2'b11, 0, 8, 1, 1, 1, exp_ret, 3'd0);
    op = OP_R; f7 = 7'b0000001; imem_ready = 1; start = 1;
    wait_state(3'd4, 10);
    start = 0;
    step(4);
    mul_done = 1;
    step(1);
    mul_done = 0;
    wait_state(3'd0, 10);

    // illegal opcode: ALUOp stays at the MUL latch value
    push(1, 2'b11, 0, 2, 1, 1, 0, 32'd0, 3'd6);
    op = OP_B; f7 = 7'd0; start = 1;
    wait_state(3'd6, 10);
    start = 0;
    step(5);
    rst_a = 0;
    @(negedge clk);
    chk("trap_cleared_by_reset", {a_ill, a_state, a_ret}, 36'd0);
    @(posedge clk); #1;
    rst_a = 1;
    exp_ret = 0;
    step(1);

    // start dropped during EXEC
    exp_ret++;
    push(0, 2'b10, 0, 4, 1, 1, 0, exp_ret, 3'd0);
    op = OP_R; f7 = 7'b0100000; imem_ready = 1; start = 1;
    wait_state(3'd3, 10);
    start = 0;
    wait_state(3'd0, 10);

    // back-to-back R/I/R
    b2b(3, 0);

    // switch to the short-timeout, 4-bit-counter instance
    step(2);
    rst_a = 0; sel = 1;
    step(1);
    rst_b = 1; exp_ret = 0;
    step(1);

    // hung multiplier: trap after 4 MULWAIT cycles
    push(1, 2'b11, 0, 6, 1, 1, 1, 32'd0, 3'd6);
    op = OP_R; f7 = 7'b0000001; imem_ready = 1; start = 1;
    wait_state(3'd4, 10);
    start = 0;
    wait_state(3'd6, 20);
    step(3);
    rst_b = 0;
    step(1);
    rst_b = 1;
    step(1);

    // done on the 4th MULWAIT cycle, same cycle the timeout would fire
    exp_ret++;
    push(0, 2'b11, 0, 7, 1, 1, 1, exp_ret, 3'd0);
    start = 1;
    wait_state(3'd4, 10);
    start = 0;
    step(3);
    mul_done = 1;
    step(1);
    mul_done = 0;
    wait_state(3'd0, 10);

    // counter wrap: 16 retirements from reset, last one reads back 0
    rst_b = 0;
    step(1);
    rst_b = 1; exp_ret = 0;
    step(1);
    b2b(16, 1);

    step(3);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
